// File: rtl/hilo_muldiv_if.sv
// Purpose : EX-stage <-> HI/LO multiply/divide unit connection (operation issue, stall, HI/LO read data).
// Ports   : master = pipeline side (drives op_valid/op/src_a/src_b/flush),
//           slave  = hilo_muldiv (drives stall_req/busy/hi_rdata/lo_rdata).
interface hilo_muldiv_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  stall_req, busy, hi_rdata, lo_rdata
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output stall_req, busy, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Purpose : HI/LO owner for the EX stage: single-cycle MULT/MULTU, MTHI/MTLO, and a
//           32-step radix-2 restoring divider for DIV/DIVU with pipeline stall request.
// Ports   : clk, rst (sync, active-high); hl (hilo_muldiv_if.slave): op_valid, op, src_a,
//           src_b, flush in; stall_req (comb), busy (registered), hi_rdata, lo_rdata out.
// Latency : MULT/MT* write at end of issue cycle; DIV result written at end of cycle 34.
// Config  : HILO_BYPASS_EN forwards the value being written this cycle onto hi/lo_rdata.
module hilo_muldiv (
  input  logic          clk,
  input  logic          rst,
  hilo_muldiv_if.slave  hl
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Divider datapath. quo_q starts as the dividend and is shifted out MSB first
  // while quotient bits are shifted in at the bottom.
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] raw_a_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        dvz_q;
  logic [4:0]  cnt_q;

  logic        is_div;
  logic        is_sdiv;
  logic        issue;
  logic        div_start;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        trial_ok;
  logic [31:0] rem_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wd;
  logic [31:0] lo_wd;
  logic        unused_diff_b32;

  assign is_div    = (hl.op == OP_DIV) || (hl.op == OP_DIVU);
  assign is_sdiv   = (hl.op == OP_DIV);
  // flush wins over a same-cycle issue; non-IDLE issues are ignored.
  assign issue     = hl.op_valid && !hl.flush && (state == S_IDLE);
  assign div_start = issue && is_div;

  assign abs_a = (is_sdiv && hl.src_a[31]) ? (32'd0 - hl.src_a) : hl.src_a;
  assign abs_b = (is_sdiv && hl.src_b[31]) ? (32'd0 - hl.src_b) : hl.src_b;

  // Signed product via sign-extended operands: the low 64 bits of the unsigned
  // product of the extended values is the two's-complement product.
  assign prod_s = {{32{hl.src_a[31]}}, hl.src_a} * {{32{hl.src_b[31]}}, hl.src_b};
  assign prod_u = {32'd0, hl.src_a} * {32'd0, hl.src_b};

  // One restoring step on the 33-bit partial remainder.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_ok = !diff[33];
  assign rem_next = trial_ok ? diff[31:0] : shifted[31:0];
  // An accepted difference is below the divisor, so its bit 32 is always zero.
  assign unused_diff_b32 = diff[32];

  assign q_fix = neg_q_q ? (32'd0 - quo_q) : quo_q;
  assign r_fix = neg_r_q ? (32'd0 - rem_q) : rem_q;

  // Single write decode shared by the register update and the optional bypass.
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_wd = 32'd0;
    lo_wd = 32'd0;
    if (issue) begin
      case (hl.op)
        OP_MULT: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_wd = prod_s[63:32];
          lo_wd = prod_s[31:0];
        end
        OP_MULTU: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_wd = prod_u[63:32];
          lo_wd = prod_u[31:0];
        end
        OP_MTHI: begin
          hi_we = 1'b1;
          hi_wd = hl.src_a;
        end
        OP_MTLO: begin
          lo_we = 1'b1;
          lo_wd = hl.src_a;
        end
        default: begin
          hi_we = 1'b0;
          lo_we = 1'b0;
        end
      endcase
    end else if ((state == S_DONE) && !hl.flush) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      hi_wd = dvz_q ? raw_a_q : r_fix;
      lo_wd = dvz_q ? 32'hFFFF_FFFF : q_fix;
    end
  end

  assign hl.stall_req = !hl.flush &&
                        (((state == S_IDLE) && hl.op_valid && is_div) ||
                         (state == S_BUSY));
  assign hl.busy = busy_q;

`ifdef HILO_BYPASS_EN
  assign hl.hi_rdata = hi_we ? hi_wd : hi_q;
  assign hl.lo_rdata = lo_we ? lo_wd : lo_q;
`else
  assign hl.hi_rdata = hi_q;
  assign hl.lo_rdata = lo_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      raw_a_q <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dvz_q   <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      if (hi_we) hi_q <= hi_wd;
      if (lo_we) lo_q <= lo_wd;

      if (hl.flush) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (div_start) begin
              rem_q   <= 32'd0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              raw_a_q <= hl.src_a;
              neg_q_q <= is_sdiv && (hl.src_a[31] ^ hl.src_b[31]);
              neg_r_q <= is_sdiv && hl.src_a[31];
              dvz_q   <= (hl.src_b == 32'd0);
              cnt_q   <= 5'd0;
              state   <= S_BUSY;
              busy_q  <= 1'b1;
            end
          end
          S_BUSY: begin
            rem_q <= rem_next;
            quo_q <= {quo_q[30:0], trial_ok};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state <= S_DONE;
            end
          end
          S_DONE: begin
            // The held DIV is still on op_valid here; it must not restart.
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
